// File: rtl/bit_serializer.sv
// bit_serializer: WIDTH-bit words in over valid/ready, serialized one bit per clock on a_out.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       gap_q;
  logic             a_out_q;
  logic             bit_valid_q;
  logic             frame_start_q;
  logic             frame_end_q;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  logic can_load;
  logic load;
  logic first_bit;
  logic next_bit;

  assign in_ready    = !reset && !hold_full_q;
  assign busy        = (state_q != IDLE) || hold_full_q;
  assign a_out       = a_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;

  assign first_bit = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
  assign next_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  // can_load: this edge ends the current frame/gap, so the shifter may take a new word.
  always_comb begin
    can_load = 1'b0;
    case (state_q)
      IDLE:   can_load = 1'b1;
      SHIFT:  can_load = !PAR_EN && (GAP_CYCLES == 0) && (cnt_q == CW'(WIDTH));
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: can_load = (GAP_CYCLES == 0);
`endif
      GAP:    can_load = (gap_q == 4'(GAP_CYCLES));
      default: can_load = 1'b1;
    endcase
  end

  assign load = can_load && hold_full_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      cnt_q         <= '0;
      gap_q         <= '0;
      a_out_q       <= IDLE_LEVEL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      if (in_valid && in_ready) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end

      if (load) begin
        state_q       <= SHIFT;
        a_out_q       <= first_bit;
        shift_q       <= MSB_FIRST ? (hold_q << 1) : (hold_q >> 1);
        cnt_q         <= CW'(1);
        bit_valid_q   <= 1'b1;
        frame_start_q <= 1'b1;
        frame_end_q   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_q         <= ^hold_q;
`endif
      end else if (can_load) begin
        state_q       <= IDLE;
        a_out_q       <= IDLE_LEVEL;
        bit_valid_q   <= 1'b0;
        frame_start_q <= 1'b0;
        frame_end_q   <= 1'b0;
      end else begin
        frame_start_q <= 1'b0;
        case (state_q)
          SHIFT: begin
            if (cnt_q != CW'(WIDTH)) begin
              a_out_q     <= next_bit;
              shift_q     <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
              cnt_q       <= cnt_q + CW'(1);
              frame_end_q <= !PAR_EN && (cnt_q == CW'(WIDTH - 1));
            end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
              state_q     <= PARITY;
              a_out_q     <= par_q;
              frame_end_q <= 1'b1;
`else
              state_q     <= GAP;
              gap_q       <= 4'd1;
              a_out_q     <= IDLE_LEVEL;
              bit_valid_q <= 1'b0;
              frame_end_q <= 1'b0;
`endif
            end
          end
`ifdef BIT_SERIALIZER_PARITY_EN
          PARITY: begin
            state_q     <= GAP;
            gap_q       <= 4'd1;
            a_out_q     <= IDLE_LEVEL;
            bit_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
          end
`endif
          GAP: gap_q <= gap_q + 4'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer: two instances (MSB-first with gap, LSB-first gapless) against a per-cycle expected-stream model.
module tb_bit_serializer;
  localparam int W  = 8;
  localparam int NC = 4096;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data     [2];
  logic         in_valid    [2];
  logic         in_ready    [2];
  logic         a_out       [2];
  logic         bit_valid   [2];
  logic         frame_start [2];
  logic         frame_end   [2];
  logic         busy        [2];

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .a_out(a_out[0]), .bit_valid(bit_valid[0]),
    .frame_start(frame_start[0]), .frame_end(frame_end[0]), .busy(busy[0]));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .a_out(a_out[1]), .bit_valid(bit_valid[1]),
    .frame_start(frame_start[1]), .frame_end(frame_end[1]), .busy(busy[1]));

  // Expected outputs indexed by cycle number (state after edge t).
  logic ea  [2][NC];
  logic ebv [2][NC];
  logic efs [2][NC];
  logic efe [2][NC];
  int   next_free [2];
  int   hold_l    [2];
  bit   pending   [2];
  bit   acc       [2];
  logic [W-1:0] wbuf [2][64];
  int   wh [2];
  int   wt [2];
  int   t;
  int   n_tests;
  int   n_fail;

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic logic idle_of(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", tag, d, t, got, exp);
    end
  endtask

  task automatic clear_from(input int d, input int s);
    for (int i = s; i < NC; i++) begin
      ea[d][i]  = idle_of(d);
      ebv[d][i] = 1'b0;
      efs[d][i] = 1'b0;
      efe[d][i] = 1'b0;
    end
  endtask

  // Word accepted at edge a: first bit appears at the later of a+1 and the end of the previous frame period.
  task automatic schedule(input int d, input int a, input logic [W-1:0] w);
    int l;
    l = (a + 1 > next_free[d]) ? a + 1 : next_free[d];
    for (int k = 0; k < W; k++) begin
      if (l + k < NC) begin
        ea[d][l+k]  = (d == 0) ? w[W-1-k] : w[k];
        ebv[d][l+k] = 1'b1;
        efs[d][l+k] = (k == 0);
        efe[d][l+k] = (PAR == 0) && (k == W - 1);
      end
    end
    if (PAR == 1 && l + W < NC) begin
      ea[d][l+W]  = ^w;
      ebv[d][l+W] = 1'b1;
      efs[d][l+W] = 1'b0;
      efe[d][l+W] = 1'b1;
    end
    next_free[d] = l + W + PAR + gap_of(d);
    pending[d]   = 1'b1;
    hold_l[d]    = l;
  endtask

  task automatic push(input int d, input logic [W-1:0] w);
    wbuf[d][wt[d] % 64] = w;
    wt[d]++;
  endtask

  task automatic cycle(input bit do_rst, input int vld_pct);
    logic exp_rdy;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      if (t < NC) begin
        check("a_out",       d, a_out[d],       ea[d][t]);
        check("bit_valid",   d, bit_valid[d],   ebv[d][t]);
        check("frame_start", d, frame_start[d], efs[d][t]);
        check("frame_end",   d, frame_end[d],   efe[d][t]);
        check("busy",        d, busy[d],        t < next_free[d]);
      end
      if (acc[d]) begin
        in_valid[d] = 1'b0;
        acc[d]      = 1'b0;
      end
    end
    reset = do_rst;
    for (int d = 0; d < 2; d++) begin
      if (!in_valid[d]) begin
        if (wh[d] != wt[d] && $urandom_range(99) < vld_pct) begin
          in_valid[d] = 1'b1;
          in_data[d]  = wbuf[d][wh[d] % 64];
        end else begin
          in_data[d] = W'($urandom);
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy = !reset && !(pending[d] && t < hold_l[d]);
      check("in_ready", d, in_ready[d], exp_rdy);
      if (reset) begin
        clear_from(d, t + 1);
        pending[d]   = 1'b0;
        next_free[d] = 0;
      end else if (in_valid[d] && exp_rdy) begin
        schedule(d, t + 1, in_data[d]);
        wh[d]++;
        acc[d] = 1'b1;
      end
    end
    @(posedge clock);
    t++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    t       = 0;
    reset   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      next_free[d] = 0;
      hold_l[d]    = 0;
      pending[d]   = 1'b0;
      acc[d]       = 1'b0;
      wh[d]        = 0;
      wt[d]        = 0;
      clear_from(d, 0);
    end
    @(posedge clock);

    repeat (3) cycle(1'b1, 0);

    push(0, 8'hA5); push(1, 8'h01);
    repeat (30) cycle(1'b0, 100);

    push(0, 8'hFF); push(0, 8'h00); push(1, 8'hF0); push(1, 8'h0F);
    repeat (40) cycle(1'b0, 100);

    // Reset during the 4th bit of 0xC3 while 0x5A sits in the holding register.
    push(0, 8'hC3); push(0, 8'h5A); push(1, 8'hC3); push(1, 8'h5A);
    repeat (5) cycle(1'b0, 100);
    cycle(1'b1, 100);
    repeat (30) cycle(1'b0, 100);

    repeat (1500) begin
      for (int d = 0; d < 2; d++)
        if (wh[d] == wt[d]) push(d, W'($urandom));
      cycle($urandom_range(299) == 0, 60);
    end
    repeat (30) cycle(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
